rx_data_sampler: RTL and testbench

Oversampling front end of the UART receiver: synchronises the serial line, runs the per-bit edge counter and produces one majority-voted bit per bit period. Its `sampled_data` output feeds the start-bit check, parity check, stop check and deserializer stages. Its strobes tell the receive FSM when a bit value is valid and when a bit period ends.

---
 rtl/rx_pkg.sv | 10 +
 rtl/rx_sync_2ff.sv | 30 +++
 rtl/rx_data_sampler.sv | 84 ++++++++
 tb/tb_rx_data_sampler.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared constants for the UART receive path: legal oversampling ratios,
// default counter width and the idle level of the serial line.
package rx_pkg;
    localparam int   PRESCALE_W_DEFAULT = 6;
    localparam int   PRESCALE_8         = 8;
    localparam int   PRESCALE_16        = 16;
    localparam int   PRESCALE_32        = 32;
    localparam int   PRESCALE_MIN       = 4;
    localparam logic RX_IDLE            = 1'b1;
endpackage

// File: rtl/rx_sync_2ff.sv
// Two-flop synchroniser for the raw serial line; resets to the idle level so
// that a reset never looks like a start bit.
module rx_sync_2ff
    import rx_pkg::*;
(
    input  logic clk_based_on_prescale,
    input  logic asy_reset,
    input  logic d,
    output logic q
);
    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
        if (!asy_reset) begin
            meta_q <= RX_IDLE;
            sync_q <= RX_IDLE;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/rx_data_sampler.sv
// UART receive oversampler: per-bit edge counter plus 3-point majority vote
// around the bit midpoint. Define RX_SYNC_EN to insert a 2-flop line synchroniser.
module rx_data_sampler
    import rx_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_W_DEFAULT
) (
    input  logic                  clk_based_on_prescale,
    input  logic                  asy_reset,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  sampler_enable,
    output logic                  sampled_data,
    output logic                  sample_valid,
    output logic                  bit_done,
    output logic [PRESCALE_W-1:0] edge_cnt
);
    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

    logic rx_s;

`ifdef RX_SYNC_EN
    rx_sync_2ff u_sync (
        .clk_based_on_prescale (clk_based_on_prescale),
        .asy_reset             (asy_reset),
        .d                     (rx_in),
        .q                     (rx_s)
    );
`else
    assign rx_s = rx_in;
`endif

    logic [PRESCALE_W-1:0] p_eff, mid, last;
    logic [PRESCALE_W-1:0] edge_cnt_d, edge_cnt_q;
    logic                  s0_d, s0_q, s1_d, s1_q;
    logic                  sampled_data_d, sampled_data_q;
    logic                  sample_valid_d, sample_valid_q;

    // Degenerate ratios fall back to 8 so the midpoint taps stay distinct.
    always_comb begin
        p_eff = (prescale < PRESCALE_W'(PRESCALE_MIN)) ? PRESCALE_W'(PRESCALE_8) : prescale;
        mid   = p_eff >> 1;
        last  = p_eff - ONE;
    end

    always_comb begin
        edge_cnt_d     = '0;
        s0_d           = s0_q;
        s1_d           = s1_q;
        sampled_data_d = sampled_data_q;
        sample_valid_d = 1'b0;
        if (sampler_enable) begin
            // >= rather than == so a stray counter value can never run away
            edge_cnt_d = (edge_cnt_q >= last) ? '0 : edge_cnt_q + ONE;
            if (edge_cnt_q == mid - ONE) s0_d = rx_s;
            if (edge_cnt_q == mid)       s1_d = rx_s;
            if (edge_cnt_q == mid + ONE) begin
                sampled_data_d = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
                sample_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
        if (!asy_reset) begin
            edge_cnt_q     <= '0;
            s0_q           <= RX_IDLE;
            s1_q           <= RX_IDLE;
            sampled_data_q <= RX_IDLE;
            sample_valid_q <= 1'b0;
        end else begin
            edge_cnt_q     <= edge_cnt_d;
            s0_q           <= s0_d;
            s1_q           <= s1_d;
            sampled_data_q <= sampled_data_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    assign sampled_data = sampled_data_q;
    assign sample_valid = sample_valid_q;
    assign edge_cnt     = edge_cnt_q;
    assign bit_done     = sampler_enable && (edge_cnt_q == last);
endmodule

// File: tb/tb_rx_data_sampler.sv
// Directed bench for rx_data_sampler: per-tick checks of counter/strobes and a
// scoreboard of expected votes built from the driven line history.
module tb_rx_data_sampler;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_in;
    logic [5:0] prescale;
    logic       en;
    logic       sampled_data, sample_valid, bit_done;
    logic [5:0] edge_cnt;

`ifdef RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    rx_data_sampler #(.PRESCALE_W(6)) dut (
        .clk_based_on_prescale (clk),
        .asy_reset             (rst_n),
        .rx_in                 (rx_in),
        .prescale              (prescale),
        .sampler_enable        (en),
        .sampled_data          (sampled_data),
        .sample_valid          (sample_valid),
        .bit_done              (bit_done),
        .edge_cnt              (edge_cnt)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    logic exp_q[$];
    logic hist[$];
    int   tcnt, pm, hidx0, hidx1, nvalid, ndone, n0, d0;
    logic data_m, vflag;

    function automatic logic maj(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic line_at(input int idx);
        int k;
        k = idx - LAT;
        return (k >= 0 && k < hist.size()) ? hist[k] : 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h tick=%0d", tag, got, exp, tcnt);
        end
    endtask

    task automatic model_reset();
        tcnt = 0; data_m = 1'b1; vflag = 1'b0; hidx0 = 0; hidx1 = 0;
        exp_q.delete();
        hist.delete();
    endtask

    // One clock tick: drive inputs, check outputs for this tick, advance the model.
    task automatic cyc(input logic e, input logic r);
        int m;
        en = e; rx_in = r;
        #1;
        chk("edge_cnt", edge_cnt, tcnt);
        chk("bit_done", bit_done, (e && tcnt == pm - 1));
        chk("sample_valid", sample_valid, vflag);
        if (sample_valid) nvalid++;
        if (bit_done) ndone++;
        if (vflag) begin
            if (exp_q.size() == 0) chk("sb_depth", exp_q.size(), 1);
            else data_m = exp_q.pop_front();
        end
        chk("sampled_data", sampled_data, data_m);
        hist.push_back(r);
        vflag = 1'b0;
        m = pm / 2;
        if (e) begin
            if (tcnt == m - 1) hidx0 = hist.size() - 1;
            if (tcnt == m)     hidx1 = hist.size() - 1;
            if (tcnt == m + 1) begin
                exp_q.push_back(maj(line_at(hidx0), line_at(hidx1), line_at(hist.size() - 1)));
                vflag = 1'b1;
            end
            tcnt = (tcnt == pm - 1) ? 0 : tcnt + 1;
        end else begin
            tcnt = 0;
        end
        @(posedge clk); #1;
    endtask

    initial begin : main
        logic [9:0] frame;
        frame = 10'b1010011010; // sent LSB first: 0,1,0,1,1,0,0,1,0,1
        nvalid = 0; ndone = 0;
        rst_n = 1'b0; rx_in = 1'b0; en = 1'b0; prescale = 6'd8; pm = 8;
        model_reset();
        #12;
        chk("rst_sampled_data", sampled_data, 1);
        chk("rst_sample_valid", sample_valid, 0);
        chk("rst_edge_cnt", edge_cnt, 0);
        chk("rst_bit_done", bit_done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);

        // P=8: low bit then high bit
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);

        // P=16 glitch rejection / acceptance
        prescale = 6'd16; pm = 16;
        cyc(1'b0, 1'b1);
        for (int t = 0; t < 16; t++) cyc(1'b1, (t == 8));
        for (int t = 0; t < 16; t++) cyc(1'b1, (t == 7 || t == 8));
        cyc(1'b0, 1'b1);

        // P=32 ten-bit frame
        prescale = 6'd32; pm = 32;
        cyc(1'b0, 1'b1);
        n0 = nvalid; d0 = ndone;
        for (int b = 0; b < 10; b++)
            for (int t = 0; t < 32; t++) cyc(1'b1, frame[b]);
        chk("frame_valids", nvalid - n0, 10);
        chk("frame_dones", ndone - d0, 10);
        cyc(1'b0, 1'b1);

        // P=8 enable dropped at tick 4, then re-enabled
        prescale = 6'd8; pm = 8;
        cyc(1'b0, 1'b1);
        n0 = nvalid;
        for (int t = 0; t < 4; t++) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("disable_no_valid", nvalid - n0, 0);
        chk("disable_hold", sampled_data, 1);
        for (int t = 0; t < 8; t++) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);

        // prescale=2 falls back to 8; async reset mid-bit
        prescale = 6'd2; pm = 8;
        for (int t = 0; t < 8; t++) cyc(1'b1, 1'b1);
        for (int t = 0; t < 8; t++) cyc(1'b1, 1'b0);
        for (int t = 0; t < 5; t++) cyc(1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_sampled_data", sampled_data, 1);
        chk("midrst_sample_valid", sample_valid, 0);
        chk("midrst_edge_cnt", edge_cnt, 0);
        chk("midrst_bit_done", bit_done, 0);
        en = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        cyc(1'b0, 1'b1);
        for (int t = 0; t < 8; t++) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);

        chk("sb_leftover", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
